// File: rtl/strobe_logger_if.sv
// Capture/readout bundle of the strobe logger.
// The producer drives the stb_* lines and out_ready; the logger drives the head-of-queue lines.
interface strobe_logger_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       stb_valid;
    logic [CHANNELS*WIDTH-1:0] stb_data;
    logic [CHANNELS*2-1:0]     stb_radix;

    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [CW-1:0]             out_chan;
    logic [1:0]                out_radix;
    logic [15:0]               out_seq;

    modport master (
        output stb_valid, stb_data, stb_radix, out_ready,
        input  out_valid, out_data, out_chan, out_radix, out_seq
    );

    modport slave (
        input  stb_valid, stb_data, stb_radix, out_ready,
        output out_valid, out_data, out_chan, out_radix, out_seq
    );
endinterface

// File: rtl/strobe_logger.sv
// Multi-channel strobe logger: per-channel pending capture, round-robin arbitration
// into a first-word-fall-through log FIFO tagged with channel, radix and sequence number.
module strobe_logger #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    strobe_logger_if.slave             bus,
    output logic [15:0]                overflow_cnt,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    chan;
        logic [1:0]       radix;
        logic [15:0]      seq;
    } entry_t;

    // Pending capture registers
    logic [WIDTH-1:0]    pend_data  [CHANNELS];
    logic [1:0]          pend_radix [CHANNELS];
    logic [CHANNELS-1:0] pend;

    // Arbitration
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       grant_idx;
    logic [CW:0]         cand;
    logic                grant_any;
    logic [CHANNELS-1:0] grant_oh;
    logic [CHANNELS-1:0] drop;
    logic [16:0]         drop_cnt;
    logic [16:0]         ovf_sum;

    // Log FIFO
    entry_t              mem [DEPTH];
    entry_t              head;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [15:0]         seq_cnt;
    logic                full;
    logic                pop;
    logic                push;
    logic                can_push;

    assign full     = (level == LW'(DEPTH));
    assign pop      = (level != '0) && bus.out_ready;
    assign can_push = !full || pop;
    assign push     = grant_any;

    // Scan pending channels starting at rr_ptr and wrapping; the first hit wins.
    always_comb begin
        // NOTE: blocking assignments here model the ordered scan; the first match must
        // block later iterations within the same evaluation.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(off);
            if (cand >= (CW+1)'(CHANNELS)) begin
                cand = cand - (CW+1)'(CHANNELS);
            end
            if (!grant_any && can_push && pend[cand[CW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // A capture is dropped when it lands on a still-pending, ungranted channel.
    assign drop = pend & ~grant_oh & bus.stb_valid;

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            drop_cnt = drop_cnt + 17'(drop[i]);
        end
    end

    assign ovf_sum = {1'b0, overflow_cnt} + drop_cnt;

    // NOTE: payload storage (pending values and FIFO memory) carries no reset; it is
    // only ever read behind a flag (pend / level) that the reset does clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.stb_valid[i]) begin
                pend_data[i]  <= bus.stb_data[i*WIDTH +: WIDTH];
                pend_radix[i] <= bus.stb_radix[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data:  pend_data[grant_idx],
                              chan:  grant_idx,
                              radix: pend_radix[grant_idx],
                              seq:   seq_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            rr_ptr       <= '0;
            seq_cnt      <= '0;
            overflow_cnt <= '0;
        end else begin
            // A fresh strobe on the granted channel re-arms it rather than counting a drop.
            pend         <= (pend & ~grant_oh) | bus.stb_valid;
            overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
            if (grant_any) begin
                rr_ptr  <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
                seq_cnt <= seq_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Head fields are forced to zero while empty so stale memory never shows.
    assign head          = mem[rd_ptr];
    assign bus.out_valid = (level != '0);
    assign bus.out_data  = bus.out_valid ? head.data  : '0;
    assign bus.out_chan  = bus.out_valid ? head.chan  : '0;
    assign bus.out_radix = bus.out_valid ? head.radix : '0;
    assign bus.out_seq   = bus.out_valid ? head.seq   : '0;

endmodule

// File: doc/strobe_logger.md
STROBE_LOGGER -- requirements
Module: strobe_logger

Interface
REQ-001 Parameter WIDTH, default 32, is the bit width of each captured channel value.
REQ-002 Parameter CHANNELS, default 4, is the number of strobe channels (>=2).
REQ-003 Parameter DEPTH, default 8, is the number of log FIFO entries (power of 2, >=2).
REQ-004 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-006 Port stb_valid, input, CHANNELS, is the per-channel capture request, sampled at the rising edge.
REQ-007 Port stb_data, input, CHANNELS*WIDTH, is the per-channel value; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port stb_radix, input, CHANNELS*2, is the per-channel display radix tag: 0 = dec, 1 = bin, 2 = oct, 3 = hex.
REQ-009 Port out_valid, output, 1, indicates that the FIFO head is valid.
REQ-010 Port out_ready, input, 1, is the consumer accept signal; a pop occurs when out_valid && out_ready.
REQ-011 Port out_data, output, WIDTH, is the FIFO head value.
REQ-012 Port out_chan, output, $clog2(CHANNELS), is the FIFO head source channel.
REQ-013 Port out_radix, output, 2, is the FIFO head radix tag.
REQ-014 Port out_seq, output, 16, is the FIFO head sequence number.
REQ-015 Port overflow_cnt, output, 16, is the saturating count of dropped captures.
REQ-016 Port level, output, $clog2(DEPTH+1), is the current FIFO occupancy.

Function
REQ-017 Each channel SHALL have one pending register holding data, radix and a pend flag.
REQ-018 On an edge with stb_valid[i]=1, the pending register SHALL load stb_data/stb_radix for channel i (capture the settled end-of-cycle value) and set pend[i].
REQ-019 If pend[i]=1, channel i is not granted on that edge, and stb_valid[i]=1, the new value SHALL overwrite the old one and overflow_cnt SHALL increment (saturating at 0xFFFF).
REQ-020 If channel i is granted on the same edge that stb_valid[i]=1, the new value SHALL become pending and no overflow SHALL be counted.
REQ-021 The round-robin arbiter SHALL grant at most one pending channel per edge: the lowest index >= rr_ptr, wrapping to index 0.
REQ-022 After a grant to channel g, rr_ptr SHALL become (g+1) mod CHANNELS; with no grant, rr_ptr SHALL hold.
REQ-023 A grant SHALL occur only if the FIFO is not full, or is full with a pop on the same edge.
REQ-024 On a grant, the FIFO SHALL write {data, chan, radix, seq_cnt} and clear pend[g] (unless REQ-020 applies), and seq_cnt SHALL increment modulo 2^16.
REQ-025 The FIFO SHALL be first-word-fall-through: out_* SHALL reflect the head entry whenever level>0.
REQ-026 out_valid SHALL equal (level != 0).
REQ-027 out_data, out_chan, out_radix and out_seq SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 Latency: stb_valid high at edge k with an empty FIFO and a winning channel SHALL produce out_valid=1 after edge k+1.
REQ-029 Simultaneous push and pop SHALL leave level unchanged; pop on empty SHALL be ignored.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 rst_n=0 SHALL immediately clear pend, rr_ptr, seq_cnt, overflow_cnt, the FIFO pointers and level, and force out_valid=0.
REQ-032 After reset, out_data, out_chan, out_radix and out_seq SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all pending and queued entries; the first capture after release SHALL carry out_seq=0.

Verification
REQ-034 Single capture: ch1 strobes 0xDEADBEEF with radix 3; out_ready=1 -> out_valid one cycle after the next edge with data 0xDEADBEEF, chan 1, radix 3, seq 0.
REQ-035 Round-robin: all 4 channels strobe in one cycle; out_ready=1 -> entries emerge in chan order 0,1,2,3 with seq 0..3 and no overflow.
REQ-036 Overwrite: out_ready=0 and the FIFO filled by ch0; ch2 strobes 5 then 7 on consecutive edges -> overflow_cnt=1; after draining, the ch2 entry carries data 7.
REQ-037 Full with concurrent pop: level=8 and ch3 pending; out_ready=1 for one edge -> level stays 8 and the ch3 entry is written.
REQ-038 Sequence wrap: 65537 captures -> out_seq sequence reaches 0xFFFF, then 0x0000.
REQ-039 Async reset: rst_n pulsed low between edges with level=5 -> out_valid=0 and level=0 immediately; the next capture has seq 0.
